// File: rtl/mem_sram_ctrl.sv
// Memory-stage data controller: each 32-bit access runs as two 16-bit SRAM phases (LO, HI).
// Define MEMCTRL_LAST_WORD_EN to add a one-word last-access cache that answers repeat reads in IDLE.
module mem_sram_ctrl #(
  parameter int ADDR_BASE    = 1024,
  parameter int SRAM_AW      = 18,
  parameter int PHASE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        val_rm,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int            CW   = $clog2(PHASE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(PHASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [29:0]   word_r;
  logic          wr_r;
  logic [31:0]   wdata_r;
  logic [31:0]   rdata_r;

  logic          req_s, start_s, hit_s;
  logic [31:0]   offs_s, hit_data_s, cur_data_s;
  logic [29:0]   in_word_s, cur_word_s;
  logic          cur_wr_s;
  logic [30:0]   half_s;
  logic [15:0]   phase_data_s;
  logic          unused_bits_s;

  assign req_s         = mem_r_en | mem_w_en;
  assign offs_s        = alu_res - 32'(ADDR_BASE);
  assign in_word_s     = offs_s[31:2];
  assign start_s       = (state_r == IDLE) & req_s & ~hit_s;
  assign unused_bits_s = ^{offs_s[1:0], half_s[30:SRAM_AW]};

`ifdef MEMCTRL_LAST_WORD_EN
  logic        cache_valid_r;
  logic [29:0] cache_tag_r;
  logic [31:0] cache_data_r;

  // Last-access cache, refreshed as every access completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid_r <= 1'b0;
      cache_tag_r   <= 30'd0;
      cache_data_r  <= 32'd0;
    end else if (state_r == DONE) begin
      cache_valid_r <= 1'b1;
      cache_tag_r   <= word_r;
      cache_data_r  <= wr_r ? wdata_r : rdata_r;
    end else begin
      cache_valid_r <= cache_valid_r;
    end
  end

  assign hit_s      = (state_r == IDLE) & mem_r_en & ~mem_w_en & cache_valid_r
                      & (cache_tag_r == in_word_s);
  assign hit_data_s = cache_data_r;
`else
  assign hit_s      = 1'b0;
  assign hit_data_s = 32'd0;
`endif

  assign ready = (state_r == DONE) | ((state_r == IDLE) & ~req_s) | hit_s;
  assign rdata = hit_s ? hit_data_s : rdata_r;

  // Operand source: live inputs while starting from IDLE, captured copies afterwards
  always_comb begin
    cur_word_s = word_r;
    cur_wr_s   = wr_r;
    cur_data_s = wdata_r;
    if (state_r == IDLE) begin
      cur_word_s = in_word_s;
      cur_wr_s   = mem_w_en;
      cur_data_s = val_rm;
    end else begin
      cur_word_s = word_r;
    end
    half_s       = {cur_word_s, (state_s == HI)};
    phase_data_s = (state_s == HI) ? cur_data_s[31:16] : cur_data_s[15:0];
  end

  // Next-state and phase counter
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = {CW{1'b0}};
        if (start_s) state_s = LO;
        else         state_s = IDLE;
      end
      LO: begin
        if (cnt_r == LAST) begin
          state_s = HI;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      HI: begin
        if (cnt_r == LAST) begin
          state_s = DONE;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      word_r  <= 30'd0;
      wr_r    <= 1'b0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (start_s) begin
        word_r  <= in_word_s;
        wr_r    <= mem_w_en;
        wdata_r <= val_rm;
      end else begin
        word_r  <= word_r;
      end
    end
  end

  // Load data: each half sampled on the final cycle of its phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r <= 32'd0;
    end else if (hit_s) begin
      rdata_r <= hit_data_s;
    end else if (!wr_r && cnt_r == LAST && state_r == LO) begin
      rdata_r[15:0] <= sram_dq_in;
    end else if (!wr_r && cnt_r == LAST && state_r == HI) begin
      rdata_r[31:16] <= sram_dq_in;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // SRAM pins are registered from the next state so they change exactly on phase entry;
  // we_n rises on the last phase cycle while address and data stay put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= {SRAM_AW{1'b0}};
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else if (state_s == LO || state_s == HI) begin
      sram_addr <= half_s[SRAM_AW-1:0];
      if (cur_wr_s) begin
        sram_dq_out <= phase_data_s;
        sram_dq_oe  <= 1'b1;
        sram_we_n   <= (cnt_s == LAST);
        sram_oe_n   <= 1'b1;
      end else begin
        sram_dq_oe  <= 1'b0;
        sram_we_n   <= 1'b1;
        sram_oe_n   <= 1'b0;
      end
    end else begin
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: directed vector table, hand-written reset/cache sequences and
// random accesses checked against a word-level memory model.
module tb_mem_sram_ctrl;

  localparam int P   = 2;
  localparam int LAT = 2 * P + 1;
`ifdef MEMCTRL_LAST_WORD_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
  logic [31:0] alu_res = 32'd0, val_rm = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  always #5 clk = ~clk;

  mem_sram_ctrl dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .rdata(rdata), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // external SRAM
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_oe_n ? 16'h0 : sram_mem[sram_addr];
  always @(negedge clk) if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // per-cycle output log of the last access (cycle 0 = request first seen)
  logic [17:0] addr_log [0:63];
  logic [15:0] dq_log   [0:63];
  logic        we_log [0:63], oe_log [0:63], dqoe_log [0:63];

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    bit done = 1'b0;
    mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
    lat = -1; rd = 32'hx;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      addr_log[k] = sram_addr; dq_log[k] = sram_dq_out;
      we_log[k] = sram_we_n; oe_log[k] = sram_oe_n; dqoe_log[k] = sram_dq_oe;
      if (ready) begin
        lat = k; rd = rdata; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_r_en = 1'b0; mem_w_en = 1'b0;
  endtask

  // word-level reference model
  logic [31:0] ref_mem [int];
  logic [31:0] rdata_exp = 32'd0;
  bit          last_valid = 1'b0;
  logic [29:0] last_word = 30'd0;

  task automatic model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
    logic [31:0] off = a - 32'd1024;
    logic [29:0] word = off[31:2];
    int key = int'(word[16:0]);
    logic [31:0] v = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
    if (!r && !w) begin
      lat = 0;
    end else if (w) begin
      ref_mem[key] = d;
      lat = LAT;
      last_valid = 1'b1; last_word = word;
    end else begin
      lat = (CACHE && last_valid && last_word == word) ? 0 : LAT;
      rdata_exp = v;
      last_valid = 1'b1; last_word = word;
    end
    rd = rdata_exp;
  endtask

  // SRAM pin sequence of a full access against the half-word address rule
  task automatic proto(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word = (a - 32'd1024) >> 2;
    logic [17:0] ea;
    logic        hi;
    logic        bad = 1'b0;
    for (int k = 1; k <= 2 * P; k++) begin
      hi = (k > P);
      ea = 18'(word * 32'd2 + {31'd0, hi});
      if (addr_log[k] !== ea) bad = 1'b1;
      if (w) begin
        if (dq_log[k] !== (hi ? d[31:16] : d[15:0])) bad = 1'b1;
        if (dqoe_log[k] !== 1'b1 || oe_log[k] !== 1'b1) bad = 1'b1;
        if (we_log[k] !== ((k == P) || (k == 2 * P))) bad = 1'b1;
      end else begin
        if (oe_log[k] !== 1'b0 || we_log[k] !== 1'b1 || dqoe_log[k] !== 1'b0) bad = 1'b1;
      end
    end
    if (we_log[LAT] !== 1'b1 || oe_log[LAT] !== 1'b1 || dqoe_log[LAT] !== 1'b0) bad = 1'b1;
    check(name, {31'd0, bad}, 32'd0);
  endtask

  typedef struct {
    logic r; logic w; logic [31:0] a; logic [31:0] d; int lat; logic [31:0] rd;
  } vec_t;

  vec_t tbl [0:10];
  int lat, mlat;
  logic [31:0] rd, mrd;

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    tbl[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, LAT, 32'h00000000};
    tbl[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        LAT, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 32'd1032, 32'h12345678, LAT, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        LAT, 32'h12345678};
    tbl[4]  = '{1'b1, 1'b1, 32'd1028, 32'hCAFEF00D, LAT, 32'h12345678};
    tbl[5]  = '{1'b0, 1'b1, 32'd1024, 32'hA5A55A5A, LAT, 32'h12345678};
    tbl[6]  = '{1'b1, 1'b0, 32'd1030, 32'h0,        LAT, 32'hCAFEF00D};
    tbl[7]  = '{1'b0, 1'b1, 32'd0,    32'h11112222, LAT, 32'hCAFEF00D};
    tbl[8]  = '{1'b1, 1'b0, 32'd1032, 32'h0,        LAT, 32'h12345678};
    tbl[9]  = '{1'b1, 1'b0, 32'd0,    32'h0,        LAT, 32'h11112222};
    tbl[10] = '{1'b0, 1'b0, 32'd1028, 32'h0,        0,   32'h11112222};
`ifdef MEMCTRL_LAST_WORD_EN
    tbl[1].lat = 0;
    tbl[3].lat = 0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst addr", {14'd0, sram_addr}, 32'd0);
    check("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      model(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, mlat, mrd);
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, lat, rd);
      check($sformatf("vec%0d lat", i), lat, tbl[i].lat);
      check($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
      if (lat == LAT) proto($sformatf("vec%0d pins", i), tbl[i].w, tbl[i].a, tbl[i].d);
      if (i == 0) begin
        check("w1 addr", {addr_log[1], addr_log[2], addr_log[3], addr_log[4]},
              {18'd2, 18'd2, 18'd3, 18'd3});
        check("w1 dq", {dq_log[1], dq_log[2]}, 32'hBEEFBEEF);
        check("w1 dq hi", {dq_log[3], dq_log[4]}, 32'hDEADDEAD);
        check("w1 we_n", {28'd0, we_log[1], we_log[2], we_log[3], we_log[4]}, 32'b0101);
      end
      if (i == 1 && lat == LAT)
        check("r1 oe_n", {27'd0, oe_log[1], oe_log[2], oe_log[3], oe_log[4], oe_log[5]}, 32'b00001);
      if (i == 5) check("base addr", {addr_log[1], addr_log[3]}, {18'd0, 18'd1});
      if (i == 7) check("wrap addr", {addr_log[1], addr_log[3]}, {18'h3FE00, 18'h3FE01});
    end

    for (int n = 0; n < 60; n++) begin
      logic        r, w;
      logic [31:0] a, d;
      int          op = $urandom_range(0, 4);
      r = (op == 1 || op == 2 || op == 4);
      w = (op >= 3);
      a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      d = $urandom;
      model(r, w, a, d, mlat, mrd);
      access(r, w, a, d, lat, rd);
      check($sformatf("rnd%0d lat", n), lat, mlat);
      check($sformatf("rnd%0d rdata", n), rd, mrd);
      if (lat == LAT && mlat == LAT) proto($sformatf("rnd%0d pins", n), w, a, d);
    end

    // give rdata a known non-zero value, then reset in the middle of a write
    model(1'b0, 1'b1, 32'd1060, 32'h0BADF00D, mlat, mrd);
    access(1'b0, 1'b1, 32'd1060, 32'h0BADF00D, lat, rd);
    model(1'b1, 1'b0, 32'd1060, 32'h0, mlat, mrd);
    access(1'b1, 1'b0, 32'd1060, 32'h0, lat, rd);
    check("pre-rst rdata", rd, 32'h0BADF00D);
    mem_w_en = 1'b1; alu_res = 32'd1040; val_rm = 32'h55AA33CC;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1; #1;
    check("midrst we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("midrst rdata", rdata, 32'd0);
    check("midrst addr", {14'd0, sram_addr}, 32'd0);
    mem_w_en = 1'b0; #1;
    check("midrst idle ready", {31'd0, ready}, 32'd1);
    @(negedge clk); rst = 1'b0;
    rdata_exp = 32'd0; last_valid = 1'b0;
    @(posedge clk); #1;
    model(1'b1, 1'b0, 32'd1060, 32'h0, mlat, mrd);
    access(1'b1, 1'b0, 32'd1060, 32'h0, lat, rd);
    check("post-rst lat", lat, LAT);
    check("post-rst rdata", rd, 32'h0BADF00D);

`ifdef MEMCTRL_LAST_WORD_EN
    model(1'b1, 1'b0, 32'd1028, 32'h0, mlat, mrd);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lat, rd);
    check("c miss lat", lat, LAT);
    check("c miss rdata", rd, mrd);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lat, rd);
    check("c hit lat", lat, 0);
    check("c hit rdata", rd, mrd);
    check("c hit oe_n", {31'd0, oe_log[0]}, 32'd1);
    check("c hit oe_n next", {31'd0, sram_oe_n}, 32'd1);
    model(1'b1, 1'b0, 32'd1036, 32'h0, mlat, mrd);
    access(1'b1, 1'b0, 32'd1036, 32'h0, lat, rd);
    check("c other lat", lat, LAT);
    check("c other rdata", rd, mrd);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1028, 32'h0, lat, rd);
    check("c after rst lat", lat, LAT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
